sdram_pll_reset_ctrl: RTL and testbench

Reset/lock sequencer on the initiator side of the SDRAM PLL's rst/locked interface. It drives the PLL reset, waits for and qualifies lock, and then releases the system reset for the SDRAM controller and video path. It detects loss of lock and re-runs the sequence. If lock is never reached, it retries a bounded number of times and then latches a failure.

---
 rtl/sdram_pll_reset_ctrl.sv | 125 ++++++++++++
 tb/tb_sdram_pll_reset_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_pll_reset_ctrl.sv
// PLL reset/lock sequencer: pulses the PLL reset, qualifies a synchronized lock,
// releases the system reset, and re-sequences on lock loss with bounded retries.
module sdram_pll_reset_ctrl #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 500000,
  parameter int STABLE_CYCLES       = 1024,
  parameter int MAX_RETRIES         = 3,
  parameter int CNT_W               = 20,
  parameter int RETRY_W             = 2
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               pll_locked,
  input  logic               relock_req,
  output logic               pll_rst,
  output logic               sys_rst,
  output logic               ready,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic               lock_lost
);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABILIZE,
    S_RUN,
    S_FAIL
  } state_e;

  localparam logic [CNT_W-1:0]   PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               lock_lost_q, lock_lost_d;
  logic               sync1_q, lock_s_q;
  logic               pll_rst_q, sys_rst_q, ready_q, fail_q;

  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    lock_lost_d = lock_lost_q;
    if (relock_req) begin
      state_d = S_RESET_PLL;
      retry_d = '0;
    end else begin
      case (state_q)
        S_RESET_PLL: if (cnt_q == PULSE_LAST) state_d = S_WAIT_LOCK;
        S_WAIT_LOCK: begin
          if (lock_s_q) begin
            state_d = S_STABILIZE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            if (retry_q == RETRY_MAX) begin
              state_d = S_FAIL;
            end else begin
              retry_d = retry_q + 1'b1;
              state_d = S_RESET_PLL;
            end
          end
        end
        // A lock drop here goes back to waiting without consuming a retry.
        S_STABILIZE: begin
          if (!lock_s_q) begin
            state_d = S_WAIT_LOCK;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = S_RUN;
            retry_d = '0;
          end
        end
        S_RUN: begin
          if (!lock_s_q) begin
            state_d     = S_RESET_PLL;
            lock_lost_d = 1'b1;
          end
        end
        S_FAIL:  state_d = S_FAIL;
        default: state_d = S_RESET_PLL;
      endcase
    end
    // The counter only matters in the timed states; park it elsewhere.
    if (relock_req || (state_d != state_q) || (state_q == S_RUN) || (state_q == S_FAIL))
      cnt_d = '0;
    else
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      lock_s_q    <= 1'b0;
      state_q     <= S_RESET_PLL;
      cnt_q       <= '0;
      retry_q     <= '0;
      lock_lost_q <= 1'b0;
      pll_rst_q   <= 1'b1;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      sync1_q     <= pll_locked;
      lock_s_q    <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      lock_lost_q <= lock_lost_d;
      // Outputs decoded from the next state so they change on the same edge as the state.
      pll_rst_q   <= (state_d == S_RESET_PLL) || (state_d == S_FAIL);
      sys_rst_q   <= (state_d != S_RUN);
      ready_q     <= (state_d == S_RUN);
      fail_q      <= (state_d == S_FAIL);
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst   = sys_rst_q;
  assign ready     = ready_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_q;
  assign lock_lost = lock_lost_q;

endmodule

// File: tb/tb_sdram_pll_reset_ctrl.sv
// Bench for sdram_pll_reset_ctrl: directed scenarios plus randomized lock/relock/reset
// traffic, all checked against a phase/elapsed-time reference model.
module tb_sdram_pll_reset_ctrl;
  localparam int RP = 4, TO = 20, ST = 8, MR = 2;
  localparam int PH_PULSE = 0, PH_WAIT = 1, PH_QUAL = 2, PH_RUN = 3, PH_DEAD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1, pll_locked = 1'b0, relock_req = 1'b0;
  logic pll_rst, sys_rst, ready, fail, lock_lost;
  logic [1:0] retry_cnt;
  logic [6:0] dut_v;

  int n_chk = 0, n_pass = 0;
  int m_phase = PH_PULSE, m_t = 0, m_retry = 0;
  bit m_lost = 0, m_s0 = 0, m_s1 = 0;

  sdram_pll_reset_ctrl #(
    .RST_PULSE_CYCLES(RP), .LOCK_TIMEOUT_CYCLES(TO), .STABLE_CYCLES(ST),
    .MAX_RETRIES(MR), .CNT_W(20), .RETRY_W(2)
  ) dut (
    .refclk(clk), .rst(rst), .pll_locked(pll_locked), .relock_req(relock_req),
    .pll_rst(pll_rst), .sys_rst(sys_rst), .ready(ready), .fail(fail),
    .retry_cnt(retry_cnt), .lock_lost(lock_lost)
  );

  always #5 clk = ~clk;
  assign dut_v = {pll_rst, sys_rst, ready, fail, lock_lost, retry_cnt};

  // Reference: a phase plus cycles elapsed in it; lock is seen two edges late.
  task automatic model_step(input bit r, input bit lk, input bit rq);
    bit ls;
    ls = m_s1;
    if (r) begin
      m_phase = PH_PULSE; m_t = 0; m_retry = 0; m_lost = 0; m_s0 = 0; m_s1 = 0;
      return;
    end
    m_s1 = m_s0;
    m_s0 = lk;
    if (rq) begin
      m_phase = PH_PULSE; m_t = 0; m_retry = 0;
      return;
    end
    case (m_phase)
      PH_PULSE: begin
        m_t++;
        if (m_t == RP) begin m_phase = PH_WAIT; m_t = 0; end
      end
      PH_WAIT: begin
        if (ls) begin
          m_phase = PH_QUAL; m_t = 0;
        end else begin
          m_t++;
          if (m_t == TO) begin
            m_t = 0;
            if (m_retry == MR) m_phase = PH_DEAD;
            else begin m_retry++; m_phase = PH_PULSE; end
          end
        end
      end
      PH_QUAL: begin
        if (!ls) begin
          m_phase = PH_WAIT; m_t = 0;
        end else begin
          m_t++;
          if (m_t == ST) begin m_phase = PH_RUN; m_t = 0; m_retry = 0; end
        end
      end
      PH_RUN: if (!ls) begin m_phase = PH_PULSE; m_t = 0; m_lost = 1; end
      default: ;
    endcase
  endtask

  function automatic logic [6:0] m_vec();
    logic prst, srst, rdy, fl;
    prst = (m_phase == PH_PULSE) || (m_phase == PH_DEAD);
    srst = (m_phase != PH_RUN);
    rdy  = (m_phase == PH_RUN);
    fl   = (m_phase == PH_DEAD);
    return {prst, srst, rdy, fl, m_lost, 2'(m_retry)};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(rst, pll_locked, relock_req);
    #1;
  endtask

  task automatic apply_rst();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_rst();
    n_chk++;
    if ({pll_rst, sys_rst, ready, fail, lock_lost, retry_cnt} !== 7'b1100000)
      $display("FAIL reset_outputs got=%b want=1100000", dut_v);
    else n_pass++;
    $display("test_reset done");
  endtask

  task automatic test_bringup();
    int n;
    pll_locked = 1'b0;
    n = 0;
    do begin
      tick(); n++;
      n_chk++;
      if (dut_v !== m_vec()) $display("FAIL bringup_model t=%0t got=%b want=%b", $time, dut_v, m_vec());
      else n_pass++;
    end while (pll_rst && n < 50);
    n_chk++;
    if (n !== RP) $display("FAIL bringup_pulse_len got=%0d want=%0d", n, RP); else n_pass++;
    repeat (10) begin
      tick();
      n_chk++;
      if (dut_v !== m_vec()) $display("FAIL bringup_wait t=%0t got=%b want=%b", $time, dut_v, m_vec());
      else n_pass++;
    end
    pll_locked = 1'b1;
    tick();
    n = 0;
    while (!ready && n < 50) begin tick(); n++; end
    n_chk++;
    if (n !== ST + 2) $display("FAIL bringup_ready_latency got=%0d want=%0d", n, ST + 2); else n_pass++;
    n_chk++;
    if ({sys_rst, retry_cnt} !== 3'b000) $display("FAIL bringup_run got=%b want=000", {sys_rst, retry_cnt});
    else n_pass++;
    $display("test_bringup ready after %0d edges", n);
  endtask

  task automatic test_glitch();
    int n;
    apply_rst();
    pll_locked = 1'b0;
    n = 0;
    while (pll_rst && n < 50) begin tick(); n++; end
    pll_locked = 1'b1;
    n = 0;
    while (!(m_phase == PH_QUAL && m_t == 5) && n < 50) begin tick(); n++; end
    pll_locked = 1'b0;
    repeat (3) begin
      tick();
      n_chk++;
      if (dut_v !== m_vec()) $display("FAIL glitch_model t=%0t got=%b want=%b", $time, dut_v, m_vec());
      else n_pass++;
    end
    n_chk++;
    if ({pll_rst, sys_rst, ready, retry_cnt} !== 5'b01000)
      $display("FAIL glitch_back_to_wait got=%b want=01000", {pll_rst, sys_rst, ready, retry_cnt});
    else n_pass++;
    pll_locked = 1'b1;
    tick();
    n = 0;
    while (!ready && n < 50) begin tick(); n++; end
    n_chk++;
    if (n !== ST + 2) $display("FAIL glitch_ready_latency got=%0d want=%0d", n, ST + 2); else n_pass++;
    n_chk++;
    if (retry_cnt !== 2'd0) $display("FAIL glitch_retry got=%0d want=0", retry_cnt); else n_pass++;
    $display("test_glitch ready after %0d edges", n);
  endtask

  task automatic test_lock_loss();
    int n;
    repeat (3) tick();
    pll_locked = 1'b0;
    tick(); tick();
    n_chk++;
    if (sys_rst !== 1'b0) $display("FAIL loss_early_sysrst got=%b want=0", sys_rst); else n_pass++;
    tick();
    n_chk++;
    if ({sys_rst, ready, pll_rst, lock_lost} !== 4'b1011)
      $display("FAIL loss_outputs got=%b want=1011", {sys_rst, ready, pll_rst, lock_lost});
    else n_pass++;
    n = 0;
    while (pll_rst && n < 50) begin tick(); n++; end
    pll_locked = 1'b1;
    n = 0;
    while (!ready && n < 60) begin
      tick(); n++;
      n_chk++;
      if (dut_v !== m_vec()) $display("FAIL loss_reseq t=%0t got=%b want=%b", $time, dut_v, m_vec());
      else n_pass++;
    end
    n_chk++;
    if ({ready, lock_lost} !== 2'b11) $display("FAIL loss_sticky got=%b want=11", {ready, lock_lost});
    else n_pass++;
    $display("test_lock_loss relocked after %0d edges", n);
  endtask

  task automatic test_rst_mid();
    int n;
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    n = 0;
    while (!(m_phase == PH_QUAL && m_t == 3) && n < 50) begin tick(); n++; end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++;
    if ({pll_rst, sys_rst, ready, lock_lost} !== 4'b1100)
      $display("FAIL rstmid_outputs got=%b want=1100", {pll_rst, sys_rst, ready, lock_lost});
    else n_pass++;
    n = 0;
    while (pll_rst && n < 50) begin tick(); n++; end
    n_chk++;
    if (n !== RP) $display("FAIL rstmid_pulse_len got=%0d want=%0d", n, RP); else n_pass++;
    $display("test_rst_mid pulse %0d", n);
  endtask

  task automatic test_never_lock();
    int n, falls, r24, r48;
    bit prev, held;
    apply_rst();
    pll_locked = 1'b0;
    n = 0; falls = 0; r24 = -1; r48 = -1;
    prev = pll_rst;
    while (!fail && n < 200) begin
      tick(); n++;
      if (prev && !pll_rst) falls++;
      prev = pll_rst;
      if (n == 24) r24 = int'(retry_cnt);
      if (n == 48) r48 = int'(retry_cnt);
      n_chk++;
      if (dut_v !== m_vec()) $display("FAIL nolock_model t=%0t got=%b want=%b", $time, dut_v, m_vec());
      else n_pass++;
    end
    n_chk++;
    if (n !== 3 * (RP + TO)) $display("FAIL nolock_fail_time got=%0d want=%0d", n, 3 * (RP + TO)); else n_pass++;
    n_chk++;
    if (falls !== 3) $display("FAIL nolock_pulses got=%0d want=3", falls); else n_pass++;
    n_chk++;
    if (r24 !== 1 || r48 !== 2) $display("FAIL nolock_retry_seq got=%0d,%0d want=1,2", r24, r48); else n_pass++;
    held = 1'b1;
    repeat (30) begin
      tick();
      if ({fail, pll_rst, sys_rst, retry_cnt} !== 5'b11110) held = 1'b0;
    end
    n_chk++;
    if (!held) $display("FAIL nolock_held got=%b want=11110", {fail, pll_rst, sys_rst, retry_cnt}); else n_pass++;
    $display("test_never_lock fail after %0d edges", n);
  endtask

  task automatic test_relock();
    int n;
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    n_chk++;
    if ({fail, retry_cnt, pll_rst} !== 4'b0001)
      $display("FAIL relock_from_fail got=%b want=0001", {fail, retry_cnt, pll_rst});
    else n_pass++;
    n = 0;
    while (pll_rst && n < 50) begin tick(); n++; end
    n_chk++;
    if (n !== RP) $display("FAIL relock_pulse_len got=%0d want=%0d", n, RP); else n_pass++;
    pll_locked = 1'b1;
    n = 0;
    while (!ready && n < 60) begin tick(); n++; end
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    n_chk++;
    if ({sys_rst, ready, pll_rst} !== 3'b101)
      $display("FAIL relock_in_run got=%b want=101", {sys_rst, ready, pll_rst});
    else n_pass++;
    $display("test_relock done");
  endtask

  task automatic test_random();
    int seg, errs;
    apply_rst();
    seg = 0; errs = 0;
    for (int i = 0; i < 4000; i++) begin
      if (seg == 0) begin
        pll_locked = ~pll_locked;
        seg = pll_locked ? int'($urandom_range(5, 120)) : int'($urandom_range(1, 90));
      end
      seg--;
      relock_req = ($urandom_range(0, 199) == 0);
      rst = ($urandom_range(0, 599) == 0);
      tick();
      n_chk++;
      if (dut_v !== m_vec()) begin
        errs++;
        if (errs <= 10) $display("FAIL random_model cyc=%0d got=%b want=%b", i, dut_v, m_vec());
      end else n_pass++;
    end
    rst = 1'b0; relock_req = 1'b0;
    $display("test_random 4000 cycles, %0d mismatching", errs);
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_glitch();
    test_lock_loss();
    test_rst_mid();
    test_never_lock();
    test_relock();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
